// File: rtl/ysyx_22050612_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store. One transaction
// at a time, round-robin grant on ties, and a watchdog that turns a hung access into an error.
module ysyx_22050612_mem_arbiter #(
    parameter int TIMER_W = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_req_addr,
    output logic        ifu_resp_valid,
    output logic [63:0] ifu_resp_rdata,
    output logic        ifu_resp_err,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [63:0] lsu_req_addr,
    input  logic        lsu_req_wen,
    input  logic [63:0] lsu_req_wdata,
    input  logic [7:0]  lsu_req_wmask,
    output logic        lsu_resp_valid,
    output logic [63:0] lsu_resp_rdata,
    output logic        lsu_resp_err,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata,

    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    typedef enum logic {SRC_IFU = 1'b0, SRC_LSU = 1'b1} src_e;

    localparam bit                 WDOG_EN    = (TIMEOUT != 0);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WDOG_EN ? TIMEOUT - 1 : 0);

    state_e             state_q, state_d;
    src_e               last_q, last_d;
    src_e               owner_q, owner_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [63:0]        addr_q, addr_d;
    logic               wen_q, wen_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [7:0]         wmask_q, wmask_d;
    logic [63:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic grant_lsu;
    logic timeout_hit;

    // On a tie the requester that did not win last time goes first.
    assign grant_lsu   = lsu_req_valid && (!ifu_req_valid || last_q == SRC_IFU);
    assign timeout_hit = WDOG_EN && (timer_q >= TIMER_LAST);

    // NOTE: every _d gets a default before the case, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        timer_d = timer_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (ifu_req_valid || lsu_req_valid) begin
                    state_d = ISSUE;
                    timer_d = '0;
                    if (grant_lsu) begin
                        owner_d = SRC_LSU;
                        last_d  = SRC_LSU;
                        addr_d  = lsu_req_addr;
                        wen_d   = lsu_req_wen;
                        wdata_d = lsu_req_wen ? lsu_req_wdata : 64'd0;
                        wmask_d = lsu_req_wen ? lsu_req_wmask : 8'd0;
                    end else begin
                        owner_d = SRC_IFU;
                        last_d  = SRC_IFU;
                        addr_d  = ifu_req_addr;
                        wen_d   = 1'b0;
                        wdata_d = 64'd0;
                        wmask_d = 8'd0;
                    end
                end
            end
            ISSUE: begin
                timer_d = timer_q + 1'b1;
                if (mem_req_ready) begin
                    state_d = WAIT;
                end else if (timeout_hit) begin
                    state_d = RESP;
                    rdata_d = 64'd0;
                    err_d   = 1'b1;
                end
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                if (mem_resp_valid) begin
                    state_d = RESP;
                    rdata_d = wen_q ? 64'd0 : mem_resp_rdata;
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d = RESP;
                    rdata_d = 64'd0;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= SRC_IFU;
            owner_q <= SRC_IFU;
            timer_q <= '0;
            addr_q  <= 64'd0;
            wen_q   <= 1'b0;
            wdata_q <= 64'd0;
            wmask_q <= 8'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        ifu_req_ready  = (state_q == IDLE) && ifu_req_valid && !grant_lsu;
        lsu_req_ready  = (state_q == IDLE) && grant_lsu;

        mem_req_valid  = (state_q == ISSUE);
        mem_req_addr   = addr_q;
        mem_req_wen    = wen_q;
        mem_req_wdata  = wdata_q;
        mem_req_wmask  = wmask_q;

        ifu_resp_valid = (state_q == RESP) && (owner_q == SRC_IFU);
        ifu_resp_rdata = ifu_resp_valid ? rdata_q : 64'd0;
        ifu_resp_err   = ifu_resp_valid && err_q;

        lsu_resp_valid = (state_q == RESP) && (owner_q == SRC_LSU);
        lsu_resp_rdata = lsu_resp_valid ? rdata_q : 64'd0;
        lsu_resp_err   = lsu_resp_valid && err_q;

        busy           = (state_q != IDLE);
    end

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Directed bench for the memory arbiter: a transaction-level reference model checked
// every cycle, plus literal expectations for latency, grant order, timeouts and reset.
module tb_ysyx_22050612_mem_arbiter;

    localparam int TIMER_W = 8;
    localparam int TIMEOUT = 4;
    // Chosen so that 0x80000000 ^ RDATA_XOR == 0x00000413_00100073.
    localparam logic [63:0] RDATA_XOR = 64'h0000_0413_8010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid = 1'b0, ifu_req_ready;
    logic [63:0] ifu_req_addr = '0;
    logic        ifu_resp_valid, ifu_resp_err;
    logic [63:0] ifu_resp_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready;
    logic [63:0] lsu_req_addr = '0, lsu_req_wdata = '0;
    logic        lsu_req_wen = 1'b0;
    logic [7:0]  lsu_req_wmask = '0;
    logic        lsu_resp_valid, lsu_resp_err;
    logic [63:0] lsu_resp_rdata;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_rdata = '0;
    logic        busy;

    always #5 clk = ~clk;

    ysyx_22050612_mem_arbiter #(.TIMER_W(TIMER_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model (one transaction record) ----------------
    function automatic bit pick_lsu(input bit ifu_v, input bit lsu_v, input bit last_lsu);
        if (ifu_v && lsu_v) return !last_lsu;
        return lsu_v;
    endfunction

    bit          m_busy = 0, m_sent = 0, m_resp = 0, m_last = 0, m_owner = 0, m_err = 0, m_wen = 0;
    int          m_age = 0;
    logic [63:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [7:0]  m_wmask = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_sent <= 0; m_resp <= 0; m_last <= 0; m_owner <= 0;
            m_age <= 0; m_err <= 0; m_rdata <= '0;
            m_addr <= '0; m_wen <= 0; m_wdata <= '0; m_wmask <= '0;
        end else if (m_resp) begin
            m_resp <= 0;
            m_busy <= 0;
        end else if (!m_busy) begin
            if (ifu_req_valid || lsu_req_valid) begin
                m_busy <= 1; m_sent <= 0; m_age <= 0;
                if (pick_lsu(ifu_req_valid, lsu_req_valid, m_last)) begin
                    m_owner <= 1; m_last <= 1;
                    m_addr  <= lsu_req_addr; m_wen <= lsu_req_wen;
                    m_wdata <= lsu_req_wen ? lsu_req_wdata : 64'd0;
                    m_wmask <= lsu_req_wen ? lsu_req_wmask : 8'd0;
                end else begin
                    m_owner <= 0; m_last <= 0;
                    m_addr  <= ifu_req_addr; m_wen <= 0; m_wdata <= '0; m_wmask <= '0;
                end
            end
        end else begin
            // m_age is the number of in-flight cycles already spent before this one.
            m_age <= m_age + 1;
            if (!m_sent && mem_req_ready) begin
                m_sent <= 1;
            end else if (m_sent && mem_resp_valid) begin
                m_resp <= 1; m_err <= 0;
                m_rdata <= m_wen ? 64'd0 : mem_resp_rdata;
            end else if (TIMEOUT != 0 && m_age >= TIMEOUT - 1) begin
                m_resp <= 1; m_err <= 1; m_rdata <= '0;
            end
        end
    end

    always @(negedge clk) begin
        logic e_mv, e_ir, e_lr, e_iv, e_lv;
        if (cyc > 0) begin
            e_ir = !m_busy && ifu_req_valid && !pick_lsu(ifu_req_valid, lsu_req_valid, m_last);
            e_lr = !m_busy && lsu_req_valid && pick_lsu(ifu_req_valid, lsu_req_valid, m_last);
            e_mv = m_busy && !m_sent && !m_resp;
            e_iv = m_resp && !m_owner;
            e_lv = m_resp && m_owner;
            check("ifu_req_ready", ifu_req_ready, e_ir);
            check("lsu_req_ready", lsu_req_ready, e_lr);
            check("mem_req_valid", mem_req_valid, e_mv);
            if (e_mv)
                check("mem_req_fields", {mem_req_addr ^ mem_req_wdata, mem_req_wmask, mem_req_wen},
                      {m_addr ^ m_wdata, m_wmask, m_wen});
            check("ifu_resp", {ifu_resp_valid, ifu_resp_err}, {e_iv, e_iv && m_err});
            check("ifu_resp_rdata", ifu_resp_rdata, e_iv ? m_rdata : 64'd0);
            check("lsu_resp", {lsu_resp_valid, lsu_resp_err}, {e_lv, e_lv && m_err});
            check("lsu_resp_rdata", lsu_resp_rdata, e_lv ? m_rdata : 64'd0);
            check("busy", busy, m_busy);
        end
    end

    // ---------------- monitor and memory responder ----------------
    int          grant_log[$];
    int          acc_log[$];
    int          resp_cnt = 0, mem_v_cnt = 0, last_resp_cyc = 0;
    logic [63:0] last_rdata = '0, hs_addr = '0;
    logic        last_err = 0, hs_seen = 0;

    always @(negedge clk) begin
        if (ifu_req_valid && ifu_req_ready) begin grant_log.push_back(0); acc_log.push_back(cyc); end
        if (lsu_req_valid && lsu_req_ready) begin grant_log.push_back(1); acc_log.push_back(cyc); end
        if (mem_req_valid) mem_v_cnt++;
        hs_seen = mem_req_valid && mem_req_ready;
        if (hs_seen) hs_addr = mem_req_addr;
        if (ifu_resp_valid || lsu_resp_valid) begin
            resp_cnt++;
            last_resp_cyc = cyc;
            last_rdata = ifu_resp_valid ? ifu_resp_rdata : lsu_resp_rdata;
            last_err = ifu_resp_valid ? ifu_resp_err : lsu_resp_err;
        end
    end

    bit auto_resp = 1, stray = 0;
    int resp_delay = 1, resp_cd = 0;

    always @(posedge clk) begin
        #2;
        mem_resp_valid = stray;
        mem_resp_rdata = stray ? 64'hDEAD_BEEF_DEAD_BEEF : 64'd0;
        if (hs_seen && auto_resp) resp_cd = resp_delay;
        if (resp_cd != 0) begin
            resp_cd--;
            if (resp_cd == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = hs_addr ^ RDATA_XOR;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ifu_req(input logic [63:0] a);
        ifu_req_valid = 1'b1;
        ifu_req_addr  = a;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ifu_req_ready) begin
                tick(1);
                ifu_req_valid = 1'b0;
                return;
            end
        end
        bound_fail("ifu_req_accept");
        ifu_req_valid = 1'b0;
    endtask

    task automatic lsu_req(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [7:0] m);
        lsu_req_valid = 1'b1;
        lsu_req_addr  = a;
        lsu_req_wen   = w;
        lsu_req_wdata = d;
        lsu_req_wmask = m;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (lsu_req_ready) begin
                tick(1);
                lsu_req_valid = 1'b0;
                return;
            end
        end
        bound_fail("lsu_req_accept");
        lsu_req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        for (int i = 0; i < 100; i++) begin
            if (resp_cnt >= target) begin
                tick(1);
                return;
            end
            @(posedge clk);
        end
        bound_fail("wait_resp");
        #1;
    endtask

    initial begin
        int n0, g0, v0;

        tick(2);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_mem_req", {mem_req_valid, mem_req_wen, mem_req_wmask}, 10'd0);
        check("reset_mem_addr", mem_req_addr, 64'd0);
        check("reset_resp", {ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err}, 4'd0);
        tick(1);

        // IFU alone, memory ready immediately, data one cycle after the handshake.
        mem_req_ready = 1'b1;
        n0 = resp_cnt; g0 = grant_log.size();
        ifu_req(64'h8000_0000);
        wait_resp(n0 + 1);
        check("t1_latency", 64'(last_resp_cyc - acc_log[g0]), 64'd3);
        check("t1_rdata", last_rdata, 64'h0000_0413_0010_0073);
        check("t1_err", last_err, 1'b0);
        check("t1_grant_ifu", 64'(grant_log[g0]), 64'd0);

        // Tie right after reset: LSU store wins, IFU follows.
        rst = 1'b1; tick(1); rst = 1'b0;
        n0 = resp_cnt; g0 = grant_log.size();
        fork
            ifu_req(64'h8000_0004);
            begin
                lsu_req(64'h8000_1000, 1'b1, 64'hAB, 8'h01);
                @(negedge clk);
                check("t2_mem_store", {mem_req_valid, mem_req_wen, mem_req_wmask}, {1'b1, 1'b1, 8'h01});
                check("t2_mem_wdata", mem_req_wdata, 64'hAB);
            end
        join
        wait_resp(n0 + 2);
        check("t2_first_lsu", 64'(grant_log[g0]), 64'd1);
        check("t2_then_ifu", 64'(grant_log[g0 + 1]), 64'd0);
        check("t2_ifu_rdata", last_rdata, 64'h0000_0413_0010_0077);

        // Both held valid for six transactions: strict alternation, 4-cycle spacing.
        n0 = resp_cnt; g0 = grant_log.size();
        fork
            for (int k = 0; k < 3; k++) ifu_req(64'h8000_0100 + 64'(8 * k));
            for (int k = 0; k < 3; k++) lsu_req(64'h8000_2000 + 64'(8 * k), 1'b0, '1, 8'hFF);
        join
        wait_resp(n0 + 6);
        for (int k = 0; k < 6; k++)
            check($sformatf("t3_grant%0d", k), 64'(grant_log[g0 + k]), (k % 2 == 0) ? 64'd1 : 64'd0);
        check("t3_spacing", 64'(acc_log[g0 + 1] - acc_log[g0]), 64'd4);

        // Memory never ready: four cycles of mem_req_valid, then an error response.
        mem_req_ready = 1'b0;
        n0 = resp_cnt; g0 = grant_log.size(); v0 = mem_v_cnt;
        ifu_req(64'h8000_0200);
        wait_resp(n0 + 1);
        check("t4_latency", 64'(last_resp_cyc - acc_log[g0]), 64'd5);
        check("t4_err", last_err, 1'b1);
        check("t4_rdata", last_rdata, 64'd0);
        check("t4_valid_cycles", 64'(mem_v_cnt - v0), 64'd4);
        mem_req_ready = 1'b1;

        // Response on the last watchdog cycle still wins.
        resp_delay = 3;
        n0 = resp_cnt; g0 = grant_log.size();
        ifu_req(64'h8000_0300);
        wait_resp(n0 + 1);
        check("t5_latency", 64'(last_resp_cyc - acc_log[g0]), 64'd5);
        check("t5_err", last_err, 1'b0);
        check("t5_rdata", last_rdata, 64'h0000_0413_0010_0373);

        // One cycle later is too late: error, and the late beat is ignored.
        resp_delay = 4;
        n0 = resp_cnt;
        lsu_req(64'h8000_3000, 1'b0, '0, '0);
        wait_resp(n0 + 1);
        check("t5_late_err", last_err, 1'b1);
        tick(3);
        check("t5_late_ignored", 64'(resp_cnt - n0), 64'd1);

        // Stray response while idle.
        n0 = resp_cnt;
        stray = 1'b1; tick(1); stray = 1'b0;
        tick(3);
        check("t5_stray", 64'(resp_cnt - n0), 64'd0);

        // Reset while waiting for memory: nothing comes back, then normal service.
        resp_delay = 3;
        n0 = resp_cnt;
        lsu_req(64'h8000_4000, 1'b0, '0, '0);
        tick(1);
        rst = 1'b1; tick(1); rst = 1'b0;
        tick(6);
        check("t6_no_resp", 64'(resp_cnt - n0), 64'd0);
        check("t6_idle", busy, 1'b0);
        resp_delay = 1;
        g0 = grant_log.size();
        ifu_req(64'h8000_0400);
        wait_resp(n0 + 1);
        check("t6_latency", 64'(last_resp_cyc - acc_log[g0]), 64'd3);
        check("t6_rdata", {last_err, last_rdata}, {1'b0, 64'h0000_0413_0010_0473});

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/ysyx_22050612_mem_arbiter.md
Name: ysyx_22050612_mem_arbiter

Overview:
- Shares the single physical memory port between the instruction-fetch unit (read-only) and the load/store path (read/write, byte mask).
- Sits between IFU/EXU and the memory interface, replacing direct per-unit memory calls.
- One outstanding transaction; round-robin grant; watchdog timeout returns an error response instead of hanging the core.

Parameters:
TIMER_W, 8, width of the watchdog counter.
TIMEOUT, 255, cycles allowed from entry to ISSUE until response; 0 disables the watchdog; must be < 2^TIMER_W.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
ifu_req_valid  in  1  fetch request
ifu_req_ready  out  1  fetch request accepted this cycle
ifu_req_addr  in  64  fetch address
ifu_resp_valid  out  1  one-cycle fetch response pulse
ifu_resp_rdata  out  64  fetch data
ifu_resp_err  out  1  fetch timed out
lsu_req_valid  in  1  load/store request
lsu_req_ready  out  1  load/store request accepted this cycle
lsu_req_addr  in  64  load/store address
lsu_req_wen  in  1  1=store, 0=load
lsu_req_wdata  in  64  store data
lsu_req_wmask  in  8  store byte mask
lsu_resp_valid  out  1  one-cycle load/store response pulse
lsu_resp_rdata  out  64  load data (0 for stores)
lsu_resp_err  out  1  load/store timed out
mem_req_valid  out  1  downstream request
mem_req_ready  in  1  downstream accepts request
mem_req_addr  out  64  downstream address
mem_req_wen  out  1  downstream write enable
mem_req_wdata  out  64  downstream write data
mem_req_wmask  out  8  downstream byte mask
mem_resp_valid  in  1  downstream response (reads and write acks)
mem_resp_rdata  in  64  downstream read data
busy  out  1  state != IDLE

Behaviour:
- Reset:
  - state=IDLE, last_grant=IFU, timer=0, owner=IFU.
  - All captured request registers are 0.
  - Every output is 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant is combinational. Only one request pending: grant it. Both pending: grant the requester that is not last_grant. First tie after reset goes to LSU.
  - Only the granted requester sees req_ready=1, and only while its valid=1. The other ready stays 0.
  - On valid&ready: capture addr/wen/wdata/wmask, set owner and last_grant, clear timer, go to ISSUE.
  - IFU captures force wen=0, wdata=0, wmask=0. LSU loads (wen=0) also force wdata=0, wmask=0.
- ISSUE:
  - mem_req_valid=1 with the registered fields, held stable.
  - mem_req_ready=1 -> WAIT. The timer keeps running and is not cleared.
- WAIT:
  - mem_req_valid=0.
  - mem_resp_valid=1 -> latch mem_resp_rdata into the resp register (0 if store), err=0, go to RESP.
- Watchdog (ISSUE and WAIT, TIMEOUT!=0):
  - Timer increments each cycle. When timer==TIMEOUT-1 and no completion event occurs this cycle: go to RESP with rdata=0, err=1.
  - Aborting in ISSUE drops mem_req_valid.
  - If the completion and the timeout fall in the same cycle, the completion wins (err=0).
- RESP:
  - Owner's resp_valid=1 for exactly one cycle, with rdata/err. The non-owner's resp outputs stay 0.
  - Next state is IDLE. No new grant is made in RESP.
- Stray responses: mem_resp_valid outside WAIT is ignored and has no effect.
- Latency: accept at cycle N; mem_req_valid at N+1; mem_req_ready at N+1 and mem_resp_valid at N+2 give resp_valid at N+3. Back-to-back requests accept no sooner than N+4.
- Requesters must accept responses unconditionally; there is no response backpressure.
- Reset mid-transaction: the transaction is abandoned with no response to either requester. A later mem_resp_valid is ignored.
- Requester valid may drop before ready with no effect; nothing is captured.

Test Plan:
- IFU only, addr=0x80000000, mem ready immediately, resp rdata=0x00000413_00100073 next cycle -> ifu_resp_valid pulses at N+3 with that data, err=0; lsu outputs stay 0.
- Simultaneous IFU(0x80000004) and LSU store (addr=0x80001000, wdata=0xAB, wmask=0x01) right after reset -> LSU granted first and mem sees wen=1, wmask=0x01. IFU is granted in the next IDLE; lsu_resp_rdata=0.
- Both requesters held valid for 6 transactions -> grants alternate LSU, IFU, LSU, IFU, LSU, IFU.
- TIMEOUT=4, mem_req_ready held 0 -> after 4 cycles in ISSUE, mem_req_valid drops and the owner gets resp_valid=1, err=1, rdata=0.
- TIMEOUT=4, mem_resp_valid arrives on the cycle the timer hits 3 -> err=0 with the real data. A stray mem_resp_valid in IDLE -> no response.
- rst asserted during WAIT, then mem_resp_valid -> no resp_valid on either side; state IDLE; a new IFU request completes normally.
